// File: rtl/shreg_frame_ctrl_pkg.sv
// Shared types for the parallel-load shift register frame controller.
package shreg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  // Bit-counter width able to hold 0..w
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shreg_frame_ctrl_if.sv
// Word-side handshake and serial-side signals of the frame controller.
interface shreg_frame_ctrl_if #(
  parameter int unsigned W = 3
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         sin;
  logic         abort;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         done;
  logic [W-1:0] rx_word;
  logic         rx_err;

  modport master (
    output din, din_valid, sin, abort,
    input  din_ready, sout, sout_valid, busy, done, rx_word, rx_err
  );

  modport slave (
    input  din, din_valid, sin, abort,
    output din_ready, sout, sout_valid, busy, done, rx_word, rx_err
  );
endinterface

// File: rtl/shreg_core.sv
// W-bit shift register: parallel load (priority) or right shift, si -> MSB, so = LSB.
module shreg_core #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  input  logic         si,
  output logic [W-1:0] q,
  output logic         so
);

  // Register contents: load wins over shift, otherwise hold
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {si, q[W-1:1]};
    end
  end

  assign so = q[0];

endmodule

// File: rtl/shreg_frame_ctrl.sv
// Frame controller: loads a word, shifts it out LSB-first on sout while
// capturing sin into rx_word; supports zero-gap back-to-back frames.
// Optional macro SHREG_CTRL_PARITY_EN adds a trailing even-parity bit (PAR).
module shreg_frame_ctrl
  import shreg_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic                 clk,
  input  logic                 clrn,
  shreg_frame_ctrl_if.slave    bus
);

  localparam int unsigned       CNT_W = cnt_w(W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(W - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, shift, accept, rx_cap, done_d, ready_win;
  logic             done_q;
  logic [W-1:0]     rx_word_q;
  logic [W-1:0]     q;
  logic             so;

  shreg_core #(.W(W)) u_core (
    .clk   (clk),
    .clrn  (clrn),
    .load  (load),
    .shift (shift),
    .d     (bus.din),
    .si    (bus.sin),
    .q     (q),
    .so    (so)
  );

  // Window in which a new word may be taken; abort in a frame blocks it
  always_comb begin
`ifdef SHREG_CTRL_PARITY_EN
    ready_win = (state_q == IDLE) || (state_q == PAR);
`else
    ready_win = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST));
`endif
  end

  assign bus.din_ready = ready_win & ~(bus.abort & (state_q != IDLE));
  assign accept        = bus.din_valid & bus.din_ready;

  // Next state, counter and datapath controls
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    rx_cap  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          shift = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
`ifdef SHREG_CTRL_PARITY_EN
            state_d = PAR;
            cnt_d   = '0;
`else
            // Last data bit: capture and, if a word is waiting, reload
            // instead of shifting so the next frame starts without a gap.
            rx_cap = 1'b1;
            done_d = 1'b1;
            cnt_d  = '0;
            if (accept) begin
              load    = 1'b1;
              shift   = 1'b0;
              state_d = SHIFT;
            end else begin
              state_d = IDLE;
            end
`endif
          end
        end
      end
`ifdef SHREG_CTRL_PARITY_EN
      PAR: begin
        cnt_d = '0;
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          rx_cap = 1'b1;
          done_d = 1'b1;
          if (accept) begin
            load    = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and done pulse registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef SHREG_CTRL_PARITY_EN
  logic tx_par_q;
  logic rx_err_q;

  // Parity of the outgoing word latched at load; the register holds the
  // full received word during PAR, so capture reads it directly.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tx_par_q  <= 1'b0;
      rx_word_q <= '0;
      rx_err_q  <= 1'b0;
    end else begin
      if (load) begin
        tx_par_q <= ^bus.din;
      end
      if (rx_cap) begin
        rx_word_q <= q;
        rx_err_q  <= (^q) ^ bus.sin;
      end
    end
  end

  assign bus.sout   = (state_q == PAR) ? tx_par_q : so;
  assign bus.rx_err = rx_err_q;
`else
  logic unused_q0;
  assign unused_q0 = q[0];

  // Receive word: the bit arriving on the last edge plus the shifted-in rest
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rx_word_q <= '0;
    end else if (rx_cap) begin
      rx_word_q <= {bus.sin, q[W-1:1]};
    end
  end

  assign bus.sout   = so;
  assign bus.rx_err = 1'b0;
`endif

  assign bus.sout_valid = (state_q != IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.rx_word    = rx_word_q;

endmodule

// File: tb/tb_shreg_frame_ctrl.sv
// Self-checking bench for shreg_frame_ctrl (W=3).
module tb_shreg_frame_ctrl;
  localparam int unsigned W  = 3;
  localparam int          WI = W;
`ifdef SHREG_CTRL_PARITY_EN
  localparam int LASTPOS = WI;
`else
  localparam int LASTPOS = WI - 1;
`endif

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  logic started = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  shreg_frame_ctrl_if #(.W(W)) bus ();

  shreg_frame_ctrl #(.W(W)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame-level model: position within the frame (-1 idle), words as arrays
  int           m_pos;
  logic [W-1:0] m_tx, m_rx_acc, m_rx_word;
  logic         m_rx_err, m_done, m_fresh;
  logic         m_acc;

  function automatic logic m_ready();
    return ((m_pos < 0) || (m_pos == LASTPOS)) && !(bus.abort && (m_pos >= 0));
  endfunction

  function automatic logic m_sout();
    if (m_pos < 0) return 1'b0;
    if (m_pos < WI) return m_tx[m_pos];
    return ^m_tx;
  endfunction

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_pos = -1; m_tx = '0; m_rx_acc = '0; m_rx_word = '0;
      m_rx_err = 1'b0; m_done = 1'b0; m_fresh = 1'b1;
    end else begin
      m_acc  = bus.din_valid && m_ready();
      m_done = 1'b0;
      if (m_pos >= 0 && bus.abort) begin
        m_pos = -1;
      end else if (m_pos >= 0) begin
        if (m_pos < WI) m_rx_acc[m_pos] = bus.sin;
        else m_rx_err = (^m_rx_acc) ^ bus.sin;
        if (m_pos == LASTPOS) begin
          m_rx_word = m_rx_acc; m_done = 1'b1; m_pos = -1;
        end else begin
          m_pos++;
        end
      end
      if (m_acc) begin
        m_tx = bus.din; m_pos = 0; m_fresh = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (started && clrn) begin
      chk("din_ready",  32'(bus.din_ready),  32'(m_ready()));
      chk("busy",       32'(bus.busy),       32'(m_pos >= 0));
      chk("sout_valid", 32'(bus.sout_valid), 32'(m_pos >= 0));
      chk("done",       32'(bus.done),       32'(m_done));
      chk("rx_word",    32'(bus.rx_word),    32'(m_rx_word));
      chk("rx_err",     32'(bus.rx_err),     32'(m_rx_err));
      if (m_pos >= 0 || m_fresh) chk("sout", 32'(bus.sout), 32'(m_sout()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic s, input logic a);
    bus.din_valid = v; bus.din = d; bus.sin = s; bus.abort = a;
  endtask

  logic [5:0] seq6;
  logic [2:0] seq3;

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    #3;
    chk("rst din_ready",  32'(bus.din_ready),  32'd1);
    chk("rst sout",       32'(bus.sout),       32'd0);
    chk("rst sout_valid", 32'(bus.sout_valid), 32'd0);
    chk("rst busy",       32'(bus.busy),       32'd0);
    chk("rst done",       32'(bus.done),       32'd0);
    chk("rst rx_word",    32'(bus.rx_word),    32'd0);
    chk("rst rx_err",     32'(bus.rx_err),     32'd0);
    #9 clrn = 1'b1;
    started = 1'b1;
    tick();

`ifndef SHREG_CTRL_PARITY_EN
    // Single frame 101, sin 1,1,0
    drive(1'b1, 3'b101, 1'b0, 1'b0); tick();
    drive(1'b0, 3'b000, 1'b1, 1'b0); chk("t1 sout c1", 32'(bus.sout), 32'd1); tick();
    drive(1'b0, 3'b000, 1'b1, 1'b0); chk("t1 sout c2", 32'(bus.sout), 32'd0); tick();
    drive(1'b0, 3'b000, 1'b0, 1'b0); chk("t1 sout c3", 32'(bus.sout), 32'd1);
    chk("t1 valid c3", 32'(bus.sout_valid), 32'd1); tick();
    chk("t1 done c4", 32'(bus.done), 32'd1);
    chk("t1 rx_word", 32'(bus.rx_word), 32'b011); tick();
    chk("t1 done c5", 32'(bus.done), 32'd0);

    // Back-to-back 110 then 001
    drive(1'b1, 3'b110, 1'b0, 1'b0); tick();
    for (int i = 0; i < 6; i++) begin
      drive((i < 3) ? 1'b1 : 1'b0, 3'b001, 1'b0, 1'b0);
      seq6[i] = bus.sout;
      if (i == 2) chk("t2 ready c3", 32'(bus.din_ready), 32'd1);
      if (i == 3) begin
        chk("t2 done c4", 32'(bus.done), 32'd1);
        chk("t2 busy c4", 32'(bus.busy), 32'd1);
      end
      if (i == 4) chk("t2 done c5", 32'(bus.done), 32'd0);
      tick();
    end
    chk("t2 sout seq", 32'(seq6), 32'b001110);
    chk("t2 done c7", 32'(bus.done), 32'd1);
    tick();

    // Backpressure: second word offered at counter 0
    drive(1'b1, 3'b010, 1'b0, 1'b0); tick();
    drive(1'b1, 3'b100, 1'b1, 1'b0); chk("t3 ready c1", 32'(bus.din_ready), 32'd0); tick();
    drive(1'b1, 3'b100, 1'b1, 1'b0); chk("t3 ready c2", 32'(bus.din_ready), 32'd0); tick();
    drive(1'b1, 3'b100, 1'b1, 1'b0); chk("t3 ready c3", 32'(bus.din_ready), 32'd1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'b000, (i == 1) ? 1'b1 : 1'b0, 1'b0);
      seq3[i] = bus.sout;
      tick();
    end
    chk("t3 sout seq", 32'(seq3), 32'b100);
    chk("t3 rx_word", 32'(bus.rx_word), 32'b010);
    tick();

    // Abort at cycle 2 of frame 111
    drive(1'b1, 3'b111, 1'b0, 1'b0); tick();
    drive(1'b0, 3'b000, 1'b1, 1'b0); tick();
    drive(1'b0, 3'b000, 1'b1, 1'b1); chk("t4 ready abort", 32'(bus.din_ready), 32'd0); tick();
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    chk("t4 valid c3", 32'(bus.sout_valid), 32'd0);
    chk("t4 ready c3", 32'(bus.din_ready), 32'd1);
    chk("t4 rx_word c3", 32'(bus.rx_word), 32'b010); tick();
    chk("t4 done c4", 32'(bus.done), 32'd0); tick();
    chk("t4 done c5", 32'(bus.done), 32'd0);
    chk("t4 rx_word c5", 32'(bus.rx_word), 32'b010);
`else
    // Parity frame 101, sin 1,0,0 then parity bit 0
    drive(1'b1, 3'b101, 1'b0, 1'b0); tick();
    drive(1'b0, 3'b000, 1'b1, 1'b0); chk("tp sout c1", 32'(bus.sout), 32'd1); tick();
    drive(1'b0, 3'b000, 1'b0, 1'b0); chk("tp sout c2", 32'(bus.sout), 32'd0); tick();
    drive(1'b0, 3'b000, 1'b0, 1'b0); chk("tp sout c3", 32'(bus.sout), 32'd1); tick();
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    chk("tp par sout", 32'(bus.sout), 32'd0);
    chk("tp par valid", 32'(bus.sout_valid), 32'd1);
    chk("tp done c4", 32'(bus.done), 32'd0); tick();
    chk("tp done c5", 32'(bus.done), 32'd1);
    chk("tp rx_word", 32'(bus.rx_word), 32'b001);
    chk("tp rx_err", 32'(bus.rx_err), 32'd1);
`endif
    tick();

    // Asynchronous reset mid-frame
    drive(1'b1, 3'b110, 1'b0, 1'b0); tick();
    drive(1'b0, 3'b000, 1'b1, 1'b0); tick();
    #2 clrn = 1'b0;
    #1;
    chk("t5 busy rst", 32'(bus.busy), 32'd0);
    chk("t5 valid rst", 32'(bus.sout_valid), 32'd0);
    chk("t5 sout rst", 32'(bus.sout), 32'd0);
    chk("t5 rx_word rst", 32'(bus.rx_word), 32'd0);
    @(posedge clk);
    #3 clrn = 1'b1;
    #1 chk("t5 ready rel", 32'(bus.din_ready), 32'd1);
    drive(1'b1, 3'b011, 1'b0, 1'b0); tick();
    drive(1'b0, 3'b000, 1'b0, 1'b0); chk("t5 sout c1", 32'(bus.sout), 32'd1); tick();
    drive(1'b0, 3'b000, 1'b1, 1'b0); chk("t5 sout c2", 32'(bus.sout), 32'd1); tick();
    drive(1'b0, 3'b000, 1'b0, 1'b0); chk("t5 sout c3", 32'(bus.sout), 32'd0); tick();
`ifdef SHREG_CTRL_PARITY_EN
    drive(1'b0, 3'b000, 1'b1, 1'b0); tick();
`endif
    chk("t5 done", 32'(bus.done), 32'd1);
    chk("t5 rx_word", 32'(bus.rx_word), 32'b010);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
